report_collector: RTL and testbench

Sits directly downstream of a generated `Automata_*` instance. It watches that instance's report-STE outputs and tags each reporting cycle with the offset of the symbol that caused it. The tagged entries are buffered in a FIFO and handed to the kernel's output writer over a valid/ready stream. It shares `run` with the automaton, so it tracks symbol positions without any extra handshake.

---
 rtl/report_pkg.sv | 13 +
 rtl/report_collector_if.sv | 15 +
 rtl/report_fifo.sv | 53 +++++
 rtl/report_collector.sv | 109 ++++++++++
 tb/tb_report_collector.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/report_pkg.sv
// Shared types for the report collector: the buffered entry layout and default sizing.
package report_pkg;

   localparam int unsigned REPORT_OFFSET_W           = 32;
   localparam int unsigned REPORT_MAX_N              = 8;
   localparam int unsigned REPORT_FIFO_DEPTH_DEFAULT = 16;

   typedef struct packed {
      logic [REPORT_OFFSET_W-1:0] offset;
      logic [REPORT_MAX_N-1:0]    report;
   } report_entry_t;

endpackage

// File: rtl/report_collector_if.sv
// Valid/ready stream carrying tagged report entries to the kernel output writer.
interface report_collector_if #(
   parameter int unsigned N_REPORTS = 1,
   parameter int unsigned OFFSET_W  = 32
);

   logic                 out_valid;
   logic                 out_ready;
   logic [OFFSET_W-1:0]  out_offset;
   logic [N_REPORTS-1:0] out_report;

   modport master (output out_valid, output out_offset, output out_report, input out_ready);
   modport slave  (input out_valid, input out_offset, input out_report, output out_ready);

endinterface

// File: rtl/report_fifo.sv
// Single-clock register FIFO with zero read latency; pointers carry an extra wrap bit.
module report_fifo
   import report_pkg::*;
#(
   parameter int unsigned DEPTH = REPORT_FIFO_DEPTH_DEFAULT,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned PTR_W = AW + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  report_entry_t     wdata,
   output report_entry_t     rdata,
   output logic              full,
   output logic              empty,
   output logic [PTR_W-1:0]  level
);

   report_entry_t    mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // A full push with a same-cycle pop overwrites the slot being read out; the read is
   // combinational so the head leaves before the write lands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push && !clear) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q[AW-1:0]];
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/report_collector.sv
// Tags automaton report cycles with their symbol offset and buffers them for the output writer.
// Optional drop counter enabled by REPORT_COLLECTOR_DROP_COUNT_EN.
module report_collector
   import report_pkg::*;
#(
   parameter int unsigned N_REPORTS  = 1,
   parameter int unsigned OFFSET_W   = 32,
   parameter int unsigned FIFO_DEPTH = REPORT_FIFO_DEPTH_DEFAULT,
   localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 clear,
   input  logic [N_REPORTS-1:0] report,
   report_collector_if.master   out,
   output logic [LVL_W-1:0]     fifo_level,
   output logic                 overflow
`ifdef REPORT_COLLECTOR_DROP_COUNT_EN
   ,
   output logic [15:0]          drop_count
`endif
);

   logic                run_q;
   logic [OFFSET_W-1:0] offset_q;
   logic [OFFSET_W-1:0] tag_q;
   logic                overflow_q;
   logic                capture;
   logic                push;
   logic                pop;
   logic                drop;
   logic                full;
   logic                empty;
   logic                unused_entry;
   report_entry_t       wdata;
   report_entry_t       rdata;

   // Reports lag their symbol by one cycle (registered in the STE), so run/offset are
   // delayed by one register to line up with them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_q      <= 1'b0;
         offset_q   <= '0;
         tag_q      <= '0;
         overflow_q <= 1'b0;
      end else if (clear) begin
         run_q      <= 1'b0;
         offset_q   <= '0;
         tag_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         run_q <= run;
         tag_q <= offset_q;
         if (run)  offset_q   <= offset_q + OFFSET_W'(1);
         if (drop) overflow_q <= 1'b1;
      end
   end

   assign capture = run_q && (|report) && !clear;
   assign pop     = out.out_valid && out.out_ready;
   assign push    = capture && (!full || pop);
   assign drop    = capture && full && !pop;

   always_comb begin
      wdata        = '0;
      wdata.offset = REPORT_OFFSET_W'(tag_q);
      wdata.report = REPORT_MAX_N'(report);
   end

   report_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   // Stale slot contents stay hidden while empty so idle outputs read as zero.
   assign out.out_valid  = !empty;
   assign out.out_offset = empty ? '0 : rdata.offset[OFFSET_W-1:0];
   assign out.out_report = empty ? '0 : rdata.report[N_REPORTS-1:0];
   assign overflow       = overflow_q;
   assign unused_entry   = ^rdata;

`ifdef REPORT_COLLECTOR_DROP_COUNT_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_cnt_q <= '0;
      end else if (clear) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_report_collector.sv
// Directed bench for report_collector with a queue-based reference model checked every cycle.
module tb_report_collector;

   localparam int unsigned NR = 2;
   localparam int unsigned OW = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic          run;
   logic          clear;
   logic [NR-1:0] report;
   logic [LW-1:0] fifo_level;
   logic          overflow;
`ifdef REPORT_COLLECTOR_DROP_COUNT_EN
   logic [15:0]   drop_count;
`endif

   report_collector_if #(.N_REPORTS(NR), .OFFSET_W(OW)) bus ();

   report_collector #(
      .N_REPORTS  (NR),
      .OFFSET_W   (OW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .run        (run),
      .clear      (clear),
      .report     (report),
      .out        (bus),
      .fifo_level (fifo_level),
      .overflow   (overflow)
`ifdef REPORT_COLLECTOR_DROP_COUNT_EN
      ,
      .drop_count (drop_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a queue of (symbol index, report) pairs built from symbol counting.
   typedef struct {
      int off;
      int rep;
   } ent_t;

   ent_t mq[$];
   int   m_syms;
   int   m_prev_idx;
   bit   m_prev_run;
   bit   m_ovf;
   int   m_drops;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || clear) begin
         mq.delete();
         m_syms = 0;
         m_prev_idx = 0;
         m_prev_run = 0;
         m_ovf = 0;
         m_drops = 0;
      end else begin
         if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
         if (m_prev_run && report != '0) begin
            if (mq.size() < DEPTH) begin
               mq.push_back('{off: m_prev_idx % (1 << OW), rep: int'(report)});
            end else begin
               m_ovf = 1;
               if (m_drops < 65535) m_drops++;
            end
         end
         m_prev_run = run;
         m_prev_idx = m_syms;
         if (run) m_syms++;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
         chk("cyc_offset", 32'(bus.out_offset), (mq.size() > 0) ? mq[0].off : 0);
         chk("cyc_report", 32'(bus.out_report), (mq.size() > 0) ? mq[0].rep : 0);
         chk("cyc_level", 32'(fifo_level), mq.size());
         chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
`ifdef REPORT_COLLECTOR_DROP_COUNT_EN
         chk("cyc_drop_count", 32'(drop_count), m_drops);
`endif
      end
   end

   task automatic cyc(input logic r, input logic [NR-1:0] rep, input logic rdy, input logic clr);
      run = r;
      report = rep;
      bus.out_ready = rdy;
      clear = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int v, input int off, input int rep,
                          input int lvl, input int ovf);
      chk({tag, "_valid"}, 32'(bus.out_valid), v);
      chk({tag, "_offset"}, 32'(bus.out_offset), off);
      chk({tag, "_report"}, 32'(bus.out_report), rep);
      chk({tag, "_level"}, 32'(fifo_level), lvl);
      chk({tag, "_overflow"}, 32'(overflow), ovf);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      run = 1'b0;
      clear = 1'b0;
      report = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 0, 0, 0, 0, 0);
`ifdef REPORT_COLLECTOR_DROP_COUNT_EN
      chk("reset_drop_count", 32'(drop_count), 0);
`endif
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Five symbols, report for the last one arrives the following cycle.
      repeat (5) cyc(1, 0, 0, 0);
      chk("t1_not_yet_valid", 32'(bus.out_valid), 0);
      cyc(0, 1, 0, 0);
      chk_out("t1", 1, 4, 1, 1, 0);
      cyc(0, 0, 1, 0);
      chk("t1_drained", 32'(fifo_level), 0);

      // Run gaps; reports while run_q is low are ignored.
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(0, 2, 0, 0);
      chk_out("t2", 1, 0, 1, 3, 0);
      cyc(0, 0, 1, 0);
      chk_out("t2_pop1", 1, 1, 1, 2, 0);
      cyc(0, 0, 1, 0);
      chk_out("t2_pop2", 1, 2, 2, 1, 0);
      cyc(0, 0, 1, 0);
      chk_out("t2_empty", 0, 0, 0, 0, 0);

      // Overflow: six reports into a depth-4 FIFO with no consumer.
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 0);
      repeat (4) cyc(1, 1, 0, 0);
      chk_out("t3_full", 1, 0, 1, 4, 0);
      cyc(1, 1, 0, 0);
      chk("t3_ovf_rise", 32'(overflow), 1);
      cyc(1, 1, 0, 0);
      chk_out("t3_after", 1, 0, 1, 4, 1);
`ifdef REPORT_COLLECTOR_DROP_COUNT_EN
      chk("t3_drop_count", 32'(drop_count), 2);
`endif
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         chk("t3_drain_order", 32'(bus.out_offset), i);
         cyc(0, 0, 1, 0);
      end
      chk_out("t3_drained", 0, 0, 0, 0, 1);

      // Full FIFO with simultaneous push and pop.
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 0);
      repeat (4) cyc(1, 1, 0, 0);
      chk_out("t4_full", 1, 0, 1, 4, 0);
      cyc(1, 1, 1, 0);
      chk_out("t4_pp1", 1, 1, 1, 4, 0);
      cyc(1, 1, 1, 0);
      cyc(0, 0, 0, 0);
      chk_out("t4_pp2", 1, 2, 1, 4, 0);

      // Offset wrap: 17th symbol of a 4-bit counter tags as 0.
      cyc(0, 0, 0, 1);
      repeat (17) cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      chk_out("t5_wrap", 1, 0, 1, 1, 0);

      // Clear against a pending push, then async reset mid-drain.
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 1);
      chk_out("t6_clear", 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      chk_out("t6_restart", 1, 0, 1, 1, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(0, 2, 0, 0);
      chk_out("t6_fill", 1, 0, 1, 3, 0);
      cyc(0, 0, 1, 0);
      chk_out("t6_drain", 1, 1, 1, 2, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("t6_async_rst", 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_out("t6_post_rst", 0, 0, 0, 0, 0);
`ifdef REPORT_COLLECTOR_DROP_COUNT_EN
      chk("t6_drop_count", 32'(drop_count), 0);
`endif
      cyc(1, 0, 0, 0);
      cyc(0, 2, 0, 0);
      chk_out("t6_after_rst", 1, 0, 2, 1, 0);
      cyc(0, 0, 1, 0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
